transmitter: RTL and testbench
==============================

TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 Parameter DATAWIDTH, default 8, payload bits per frame.
REQ-002 Parameter CLK_FREQ, default 100000000, clock frequency in Hz.
REQ-003 Parameter BAUD_RATE, default 9600, line bit rate in bits/s.
REQ-004 Derived constant CLKS_PER_BIT SHALL be CLK_FREQ/BAUD_RATE, integer division (10416 at defaults).
REQ-005 Port clk, input, 1 bit: single clock; all sequential logic on rising edge.
REQ-006 Port i_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port i_data, input, DATAWIDTH bits: payload to send.
REQ-008 Port i_transmit, input, 1 bit: level-sensitive transmit enable.
REQ-009 Port o_tx_data, output, 1 bit: serial line; idle high.
REQ-010 Port o_busy, output, 1 bit: high from the first start-bit cycle to the last stop-bit cycle inclusive.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP, plus PARITY when TX_PARITY_EN is defined.
REQ-012 In IDLE: o_tx_data=1, o_busy=0, bit counter and baud counter held at 0.
REQ-013 In IDLE with i_transmit=1 at a rising edge, i_data SHALL be latched into a shift register and the FSM SHALL enter START; o_tx_data goes 0 on that edge (1-cycle latency).
REQ-014 Each bit (start, data, parity, stop) SHALL be driven for exactly CLKS_PER_BIT clock cycles, counted by a baud counter that runs 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
REQ-015 START drives 0; DATA drives the latched bits LSB first, DATAWIDTH bits; STOP drives 1.
REQ-016 Changes on i_data after latching SHALL NOT affect the frame in progress.
REQ-017 At the end of STOP, if i_transmit=1 the FSM SHALL latch the current i_data and enter START on the same edge (back-to-back frames, no idle gap); otherwise it enters IDLE.
REQ-018 Deasserting i_transmit mid-frame SHALL NOT abort the frame; the frame completes through STOP.
REQ-019 Frame length SHALL be (DATAWIDTH+2)*CLKS_PER_BIT cycles without parity, (DATAWIDTH+3)*CLKS_PER_BIT with parity.
REQ-020 o_tx_data SHALL be driven from a register (glitch-free).

Reset
REQ-021 i_reset=0 SHALL immediately, without waiting for a clock edge, force state IDLE, o_tx_data=1, o_busy=0, and clear the counters and the shift register.
REQ-022 Reset asserted mid-frame SHALL abort the frame; after release, a new frame starts only via REQ-013.
REQ-023 Reset release is synchronous-safe: the first possible START is on the first rising edge with i_reset=1 and i_transmit=1.

Configuration
REQ-024 Macro TX_PARITY_EN: when defined, a PARITY state between DATA and STOP SHALL drive the even parity bit of the latched payload (XOR of all data bits) for CLKS_PER_BIT cycles.
REQ-025 Without TX_PARITY_EN, no PARITY state or parity logic SHALL exist and DATA proceeds directly to STOP.

Verification
REQ-026 Reset: hold i_reset=0 with i_transmit=1 -> o_tx_data=1 and o_busy=0 throughout.
REQ-027 Single frame: release reset, i_data=8'h33, i_transmit=1 for one frame then 0 -> line reads 0, 1,1,0,0,1,1,0,0, 1, each bit 10416 cycles, then idle high.
REQ-028 Back-to-back: i_transmit held 1, i_data changed to 8'hAA then 8'h0F mid-frame -> frames carry 0x33, 0xAA, 0x0F in order with no idle gap; each value is taken at its frame start, and a mid-frame change does not alter the frame in progress.
REQ-029 Mid-frame reset: assert i_reset=0 during DATA -> o_tx_data=1 asynchronously, FSM in IDLE, no partial resume.
REQ-030 Parity build with TX_PARITY_EN: i_data=8'h07 -> parity bit 1 between data and stop, frame length 11*10416 cycles.
REQ-031 Timing check with CLK_FREQ=1000, BAUD_RATE=100 -> every bit lasts exactly 10 cycles; start bit appears 1 cycle after i_transmit is sampled high.

Source files
------------

// File: rtl/transmitter.sv
// UART-style serial transmitter: start bit, DATAWIDTH data bits LSB first, stop bit.
// Optional even parity bit between data and stop when TX_PARITY_EN is defined.
module transmitter #(
    parameter int DATAWIDTH = 8,
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic [DATAWIDTH-1:0] i_data,
    input  logic                 i_transmit,
    output logic                 o_tx_data,
    output logic                 o_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATAWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               r_state;
    logic [BAUD_W-1:0]    r_baud;
    logic [BIT_W-1:0]     r_bit;
    logic [DATAWIDTH-1:0] r_shift;
    logic                 r_tx;
    logic                 r_busy;
`ifdef TX_PARITY_EN
    logic                 r_parity;
`endif
    logic                 w_bit_end;

    assign w_bit_end = (r_baud == BAUD_LAST);
    assign o_tx_data = r_tx;
    assign o_busy    = r_busy;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
`ifdef TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (i_transmit) begin
                        r_shift  <= i_data;
`ifdef TX_PARITY_EN
                        r_parity <= ^i_data;
`endif
                        r_state  <= START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_bit   <= '0;
`ifdef TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            // The shift register always presents the next bit at position 0.
                            r_bit   <= r_bit + 1'b1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (i_transmit) begin
                            // Back-to-back: next frame starts on this edge with no idle gap.
                            r_shift  <= i_data;
`ifdef TX_PARITY_EN
                            r_parity <= ^i_data;
`endif
                            r_state  <= START;
                            r_tx     <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for transmitter: stimulus queues expected frames, a line monitor
// decodes the serial output and compares. Honours TX_PARITY_EN for frame layout.
module tb_transmitter;

    localparam int DW  = 8;
    localparam int CF  = 1000;
    localparam int BR  = 100;
    localparam int CPB = CF / BR;
`ifdef TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int FL = NBITS * CPB;

    logic          clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_transmit = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_tx_data;
    logic          o_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         start;
    } exp_t;

    exp_t q[$];
    bit   in_frame = 1'b0;

    transmitter #(
        .DATAWIDTH(DW),
        .CLK_FREQ (CF),
        .BAUD_RATE(BR)
    ) dut (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_data    (i_data),
        .i_transmit(i_transmit),
        .o_tx_data (o_tx_data),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Line monitor: decodes one frame of FL cycles, then pops and compares.
    initial begin
        int          fc;
        logic [15:0] bits;
        bit          stable;
        bit          busy_ok;
        int          start_c;
        exp_t        e;
        fc = 0; bits = '0; stable = 1'b1; busy_ok = 1'b1; start_c = 0;
        forever begin
            @(negedge clk);
            if (!i_reset) begin
                in_frame = 1'b0;
                check("reset_tx", o_tx_data, 1);
                check("reset_busy", o_busy, 0);
            end else if (!in_frame) begin
                if (o_tx_data === 1'b0) begin
                    in_frame = 1'b1;
                    fc = 0; bits = '0; stable = 1'b1; busy_ok = 1'b1;
                    start_c = cyc;
                end else begin
                    check("idle_tx", o_tx_data, 1);
                    check("idle_busy", o_busy, 0);
                end
            end
            if (in_frame && i_reset) begin
                if (fc % CPB == 0) bits[fc / CPB] = o_tx_data;
                else if (o_tx_data !== bits[fc / CPB]) stable = 1'b0;
                if (o_busy !== 1'b1) busy_ok = 1'b0;
                fc++;
                if (fc == FL) begin
                    in_frame = 1'b0;
                    if (q.size() == 0) begin
                        check("unexpected_frame", q.size(), 1);
                    end else begin
                        e = q.pop_front();
                        check("start_cycle", start_c, e.start);
                        check("start_bit", bits[0], 0);
                        check("data", bits[DW:1], e.data);
`ifdef TX_PARITY_EN
                        check("parity", bits[DW+1], e.par);
`endif
                        check("stop_bit", bits[NBITS-1], 1);
                        check("bit_stable", stable, 1);
                        check("busy_in_frame", busy_ok, 1);
                    end
                end
            end
        end
    end

    initial begin
        int s;
        logic [7:0] vec_d [4];
        logic       vec_p [4];
        vec_d = '{8'h80, 8'h07, 8'hFF, 8'h00};
        vec_p = '{1'b1,  1'b1,  1'b0,  1'b0};

        // Reset held with transmit requested: line must stay idle.
        i_reset = 1'b0; i_transmit = 1'b1; i_data = 8'h33;
        step(20);

        // Single frame, start one cycle after transmit sampled high.
        q.push_back(exp_t'{8'h33, 1'b0, cyc + 1});
        i_reset = 1'b1;
        step(5);
        i_transmit = 1'b0;
        step(FL + 20);

        // Back-to-back frames with mid-frame data changes.
        i_data = 8'h33; i_transmit = 1'b1;
        s = cyc + 1;
        q.push_back(exp_t'{8'h33, 1'b0, s});
        q.push_back(exp_t'{8'hAA, 1'b0, s + FL});
        q.push_back(exp_t'{8'h0F, 1'b0, s + 2 * FL});
        step(30);
        i_data = 8'hAA;
        step(FL);
        i_data = 8'h0F;
        step(FL);
        i_data = 8'h55; i_transmit = 1'b0;
        step(FL + 20);

        // Mid-frame reset during DATA while the line is low.
        i_data = 8'h5A; i_transmit = 1'b1;
        step(1);
        i_transmit = 1'b0;
        step(3 * CPB + 4);
        i_reset = 1'b0;
        #1;
        check("async_tx", o_tx_data, 1);
        check("async_busy", o_busy, 0);
        i_data = 8'hFF;
        step(5);
        i_reset = 1'b1;
        step(30);

        // Boundary payloads, one frame each.
        for (int i = 0; i < 4; i++) begin
            i_data = vec_d[i]; i_transmit = 1'b1;
            q.push_back(exp_t'{vec_d[i], vec_p[i], cyc + 1});
            step(1);
            i_transmit = 1'b0;
            step(FL + 5);
        end

        for (int i = 0; i < 2000 && (q.size() != 0 || in_frame); i++) step(1);
        check("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
